// File: rtl/pa_sweep_pkg.sv
// Shared types for the PA16 frequency-sweep sequencer: FSM states,
// default widths and the latched sweep program.
package pa_sweep_pkg;

    localparam int PA_W     = 16;
    localparam int PA_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    typedef struct packed {
        logic [PA_W-1:0]     fcw_start;
        logic [PA_W-1:0]     fcw_step;
        logic [PA_CNT_W-1:0] n_steps;
        logic [PA_CNT_W-1:0] dwell;
        logic                mode;
    } sweep_prog_t;

endpackage

// File: rtl/pa_sweep_ctrl_adder16.sv
// 16-bit ripple-style adder shared with the accumulator datapath; the carry
// out is dropped so sums wrap modulo 2^16.
module adder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);

    assign sum_o = a_i + b_i + {15'd0, cin_i};

endmodule

// File: rtl/pa_sweep_ctrl.sv
// Frequency-sweep sequencer: latches a sweep program on start, reloads the
// accumulator phase and steps the FCW by a signed increment with a dwell per word.
module pa_sweep_ctrl
    import pa_sweep_pkg::*;
#(
    parameter int W     = PA_W,
    parameter int CNT_W = PA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [W-1:0]     fcw_start,
    input  logic [W-1:0]     fcw_step,
    input  logic [CNT_W-1:0] n_steps,
    input  logic [CNT_W-1:0] dwell,
    output logic [W-1:0]     fcw,
    output logic             pa_rst_n,
    output logic             step_strobe,
    output logic             busy,
    output logic             done
);

    sweep_state_e     state_q, state_d;
    sweep_prog_t      shadow_q, shadow_d;
    logic [W-1:0]     fcw_q, fcw_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic             strobe_q, strobe_d;
    logic             pa_rst_n_q, busy_q, done_q;

    logic [W-1:0]     prog_start_s, prog_step_s, sum_s;
    logic [CNT_W-1:0] prog_n_steps_s, prog_dwell_s;

    assign prog_start_s   = W'(shadow_q.fcw_start);
    assign prog_step_s    = W'(shadow_q.fcw_step);
    assign prog_n_steps_s = CNT_W'(shadow_q.n_steps);
    assign prog_dwell_s   = CNT_W'(shadow_q.dwell);

    // Wrapping increment of the current FCW by the signed step.
    if (W == 16) begin : g_add16
        adder16 u_add (
            .a_i   (fcw_q),
            .b_i   (prog_step_s),
            .cin_i (1'b0),
            .sum_o (sum_s)
        );
    end else begin : g_add_gen
        assign sum_s = fcw_q + prog_step_s;
    end

    // Next-state, shadow capture, FCW stepping and counter updates.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fcw_d       = fcw_q;
        step_cnt_d  = step_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        strobe_d    = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            fcw_d       = '0;
            step_cnt_d  = '0;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d            = LOAD;
                        shadow_d.fcw_start = PA_W'(fcw_start);
                        shadow_d.fcw_step  = PA_W'(fcw_step);
                        shadow_d.n_steps   = PA_CNT_W'(n_steps);
                        shadow_d.dwell     = PA_CNT_W'(dwell);
                        shadow_d.mode      = mode;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    state_d     = DWELL;
                    fcw_d       = prog_start_s;
                    step_cnt_d  = '0;
                    dwell_cnt_d = '0;
                end
                DWELL: begin
                    if (dwell_cnt_q == prog_dwell_s) begin
                        if (step_cnt_q < prog_n_steps_s) begin
                            fcw_d       = sum_s;
                            step_cnt_d  = step_cnt_q + CNT_W'(1);
                            dwell_cnt_d = '0;
                            strobe_d    = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Repeat mode goes straight back to LOAD so the phase is reloaded each pass.
                    if (shadow_q.mode) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, program and output registers; status outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            fcw_q       <= '0;
            step_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            strobe_q    <= 1'b0;
            pa_rst_n_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fcw_q       <= fcw_d;
            step_cnt_q  <= step_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            strobe_q    <= strobe_d;
            pa_rst_n_q  <= (state_d != LOAD);
            busy_q      <= (state_d == LOAD) || (state_d == DWELL);
            done_q      <= (state_d == DONE);
        end
    end

    assign fcw         = fcw_q;
    assign pa_rst_n    = pa_rst_n_q;
    assign step_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pa_sweep_ctrl.sv
// Scoreboard bench for pa_sweep_ctrl: expected per-cycle output records are queued
// by the stimulus and popped by a monitor whenever the sequencer is active.
module tb_pa_sweep_ctrl;

    typedef struct packed {
        logic        busy;
        logic        rst_n;
        logic        strobe;
        logic        done;
        logic [15:0] fcw;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [15:0] fcw_start;
    logic [15:0] fcw_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic [15:0] fcw;
    logic        pa_rst_n;
    logic        step_strobe;
    logic        busy;
    logic        done;

    rec_t        exp_q[$];
    rec_t        mon_got;
    rec_t        mon_exp;
    int          checks   = 0;
    int          failures = 0;
    int          rec_idx  = 0;
    logic [15:0] last_fcw = 16'h0000;

    pa_sweep_ctrl #(.W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .fcw_start   (fcw_start),
        .fcw_step    (fcw_step),
        .n_steps     (n_steps),
        .dwell       (dwell),
        .fcw         (fcw),
        .pa_rst_n    (pa_rst_n),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every active output cycle must match the next queued record.
    always @(posedge clk) begin
        #1;
        if (busy || done || !pa_rst_n || step_strobe) begin
            mon_got = '{busy, pa_rst_n, step_strobe, done, fcw};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL rec%0d got=%h exp=%h", rec_idx, mon_got, mon_exp);
                end
                rec_idx++;
            end
        end
    end

    task automatic put(input rec_t x, inout int cnt, input int limit);
        if (limit < 0 || cnt < limit) exp_q.push_back(x);
        cnt++;
    endtask

    // Expected cycle trace of a sweep: LOAD, (n+1) words of (dw+1) cycles, DONE.
    task automatic push_prog(input logic [15:0] fs, input logic [15:0] st, input int n,
                             input int dw, input int reps, input int limit);
        int          cnt;
        logic [15:0] f;
        cnt = 0;
        f   = last_fcw;
        for (int r = 0; r < reps; r++) begin
            put('{1'b1, 1'b0, 1'b0, 1'b0, f}, cnt, limit);
            for (int i = 0; i <= n; i++) begin
                f = fs + st * 16'(i);
                for (int j = 0; j <= dw; j++) begin
                    put('{1'b1, 1'b1, (i > 0 && j == 0), 1'b0, f}, cnt, limit);
                end
            end
            put('{1'b0, 1'b1, 1'b0, 1'b1, f}, cnt, limit);
        end
        last_fcw = f;
    endtask

    task automatic launch(input logic [15:0] fs, input logic [15:0] st, input logic [15:0] n,
                          input logic [15:0] dw, input logic md);
        @(negedge clk);
        fcw_start = fs;
        fcw_step  = st;
        n_steps   = n;
        dwell     = dw;
        mode      = md;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        fcw_start = 16'h0000;
        fcw_step  = 16'h0000;
        n_steps   = 16'd0;
        dwell     = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_fcw", 32'(fcw), 32'h0);
        chk("rst_pa_rst_n", 32'(pa_rst_n), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_strobe", 32'(step_strobe), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic sweep: 0x0100..0x0130 by 0x0010, each held 2 cycles.
        push_prog(16'h0100, 16'h0010, 3, 1, 1, -1);
        launch(16'h0100, 16'h0010, 16'd3, 16'd1, 1'b0);
        drain("basic_drain");
        chk("basic_hold_fcw", 32'(fcw), 32'h0130);

        // Shadowing: inputs change and start re-pulses while busy.
        push_prog(16'h2000, 16'h0001, 2, 1, 1, -1);
        launch(16'h2000, 16'h0001, 16'd2, 16'd1, 1'b0);
        fcw_start = 16'h7777;
        fcw_step  = 16'h0100;
        n_steps   = 16'd9;
        dwell     = 16'd5;
        mode      = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("shadow_drain");
        chk("shadow_hold_fcw", 32'(fcw), 32'h2002);

        // Wrap with negative step: 0x0008, 0x0000, 0xFFF8.
        push_prog(16'h0008, 16'hFFF8, 2, 0, 1, -1);
        launch(16'h0008, 16'hFFF8, 16'd2, 16'd0, 1'b0);
        drain("wrap_drain");
        chk("wrap_hold_fcw", 32'(fcw), 32'hFFF8);

        // Degenerate program: one word for one cycle, then done.
        push_prog(16'h4321, 16'h1111, 0, 0, 1, -1);
        launch(16'h4321, 16'h1111, 16'd0, 16'd0, 1'b0);
        drain("degen_drain");

        // Abort in the dwell of step 2, after 11 active cycles.
        push_prog(16'h1000, 16'h0100, 3, 3, 1, 11);
        launch(16'h1000, 16'h0100, 16'd3, 16'd3, 1'b0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        last_fcw = 16'h0000;
        chk("abort_fcw", 32'(fcw), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_pa_rst_n", 32'(pa_rst_n), 32'h1);
        chk("abort_done", 32'(done), 32'h0);
        drain("abort_drain");

        // start together with abort in IDLE must not start a sweep.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'h0);
        chk("idle_abort_pa_rst_n", 32'(pa_rst_n), 32'h1);
        @(negedge clk);
        chk("idle_abort_busy2", 32'(busy), 32'h0);

        // Repeat mode: three 8-cycle periods, aborted during the third DONE.
        push_prog(16'h0500, 16'h0050, 1, 2, 3, -1);
        launch(16'h0500, 16'h0050, 16'd1, 16'd2, 1'b1);
        repeat (23) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        last_fcw = 16'h0000;
        chk("rep_abort_fcw", 32'(fcw), 32'h0);
        chk("rep_abort_busy", 32'(busy), 32'h0);
        drain("rep_drain");

        // Reset mid-sweep returns every output to its reset value.
        push_prog(16'h0A00, 16'h0011, 5, 1, 1, 5);
        launch(16'h0A00, 16'h0011, 16'd5, 16'd1, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_fcw = 16'h0000;
        chk("mid_rst_fcw", 32'(fcw), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_pa_rst_n", 32'(pa_rst_n), 32'h1);
        chk("mid_rst_strobe", 32'(step_strobe), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        drain("mid_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pa_sweep_ctrl.md
# pa_sweep_ctrl

Frequency-sweep sequencer for the 16-bit phase accumulator (PA16) feeding the CORDIC/ROM sine path. On a start request it latches a sweep program, reloads the accumulator phase, and steps the frequency control word (FCW) from a start value by a signed increment, holding each word for a programmable dwell. It supports single-shot and repeating linear chirps. It is the only driver of the accumulator's `fcw` input and active-low reload.

## Interface
Parameters:
- `W`, 16: FCW width; must match the accumulator width.
- `CNT_W`, 16: width of the step and dwell counters.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: sweep request; sampled only in IDLE.
- `abort`, in, 1: terminates any sweep in progress; takes priority over everything except `reset`.
- `mode`, in, 1: 0 = single shot, 1 = repeat until abort.
- `fcw_start`, in, W: first FCW of the sweep.
- `fcw_step`, in, W: signed two's-complement FCW increment.
- `n_steps`, in, CNT_W: number of increments; the sweep has `n_steps+1` frequencies.
- `dwell`, in, CNT_W: each FCW is held for `dwell+1` cycles.
- `fcw`, out, W: registered FCW to the accumulator.
- `pa_rst_n`, out, 1: registered active-low accumulator reload (phase ← init).
- `step_strobe`, out, 1: one-cycle pulse on each cycle where `fcw` takes a new incremented value.
- `busy`, out, 1: high in LOAD and DWELL.
- `done`, out, 1: one-cycle pulse at normal sweep completion.

## Operation
- States: IDLE, LOAD, DWELL, DONE.
- **IDLE**
  - `start`=1 and `abort`=0 → LOAD.
  - Latch `fcw_start`, `fcw_step`, `n_steps`, `dwell`, `mode` into shadow registers. Later input changes have no effect until the next start.
- **LOAD** (exactly 1 cycle)
  - `pa_rst_n`=0 and `busy`=1 during this cycle.
  - Next cycle: `fcw`←`fcw_start`, step_cnt←0, dwell_cnt←0, state → DWELL.
- **DWELL**
  - dwell_cnt increments each cycle.
  - When dwell_cnt==dwell and step_cnt<n_steps:
    - `fcw`←`fcw`+`fcw_step`, wrapping modulo 2^W with no saturation.
    - step_cnt++, dwell_cnt←0, `step_strobe`=1 on the cycle the new `fcw` appears.
  - When dwell_cnt==dwell and step_cnt==n_steps: → DONE.
- **DONE** (exactly 1 cycle)
  - `done`=1, `busy`=0.
  - `mode`=1 → LOAD (phase reloaded each repetition); `mode`=0 → IDLE.
  - `fcw` holds its final value until the next LOAD or an abort.
- **abort** in LOAD, DWELL or DONE:
  - Next cycle: state=IDLE, `fcw`=0, `pa_rst_n`=1, `busy`=0.
  - No `done` or `step_strobe` pulse.
  - In IDLE, `abort` has no effect, and `abort`+`start` together means no start.
- `start` outside IDLE is ignored and is not queued.
- `n_steps`=0: a single frequency held `dwell+1` cycles, then DONE. `dwell`=0: FCW changes every cycle.
- Reset values: state=IDLE, `fcw`=0, `pa_rst_n`=1, `step_strobe`=0, `busy`=0, `done`=0, all counters 0. Reset mid-sweep behaves like abort, except that it also clears the shadow registers.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- With `start` sampled at edge k:
  - LOAD is visible after edge k (`busy`=1, `pa_rst_n`=0).
  - `fcw`=`fcw_start` is visible after edge k+1.
- Each FCW value is present for exactly `dwell+1` cycles.
- Busy duration = 1 + (n_steps+1)(dwell+1) cycles, then 1 DONE cycle.
- Start-to-start minimum (single shot) = busy duration + 2 cycles.
- In repeat mode, LOAD follows DONE immediately, so the FCW drops back to `fcw_start` after exactly one DONE cycle plus one LOAD cycle.

## Structure
- Package `pa_sweep_pkg`:
  - state enum (IDLE, LOAD, DWELL, DONE);
  - default `W`/`CNT_W` localparams;
  - a sweep-program struct (start, step, n_steps, dwell, mode) used for the shadow registers.
- Sub-module: reuse the existing `adder16` for the `fcw`+`fcw_step` increment (carry-in 0) when `W`=16; use a generic adder otherwise.
- Counters and FSM stay in the top module.

## Test plan
- **Basic sweep:** `fcw_start`=0x0100, `fcw_step`=0x0010, `n_steps`=3, `dwell`=1.
  - `fcw` sequence 0x0100, 0x0110, 0x0120, 0x0130, each value held 2 cycles.
  - 3 `step_strobe` pulses, 1 `done`, busy length 9 cycles.
  - `pa_rst_n` low for 1 cycle.
- **Wrap and negative step:** `fcw_start`=0x0008, `fcw_step`=0xFFF8 (−8), `n_steps`=2, `dwell`=0.
  - `fcw` sequence 0x0008, 0x0000, 0xFFF8.
- **Degenerate program:** `n_steps`=0, `dwell`=0.
  - `fcw`=`fcw_start` for 1 cycle, `done` on the next cycle, no `step_strobe`.
- **Abort:** abort asserted mid-DWELL of step 2.
  - Next cycle IDLE, `fcw`=0, no `done`.
  - `start`+`abort` asserted together in IDLE → stays IDLE.
- **Repeat mode:** `mode`=1, `n_steps`=1, `dwell`=2.
  - Periodic pattern LOAD, 3×`fcw_start`, 3×(`fcw_start`+`fcw_step`), DONE, LOAD…
  - `done` every 8 cycles and `pa_rst_n` pulse every 8 cycles, until abort.
- **Shadowing and reset:**
  - Inputs changed during a sweep do not alter it.
  - `start` pulsed while busy is ignored.
  - `reset` mid-sweep → all outputs at reset values on the next cycle.
